ibuffer_per_warp: RTL

- Per-warp instruction buffer between decode and the per-warp scoreboard/issue stage.
- Holds up to NUM_ENTRIES decoded instructions in order.
- Presents the head instruction's register fields to the scoreboard for hazard checking.
- Raises ready_IB_Issue when the head can issue; pops the head on issue_grant. A branch flush discards all contents.

---
 rtl/ibuffer_per_warp_pkg.sv | 28 ++
 rtl/ibuffer_per_warp_if.sv | 55 +++++
 rtl/ibuf_fifo.sv | 57 +++++
 rtl/ibuffer_per_warp.sv | 81 ++++++++
 4 files changed

// File: rtl/ibuffer_per_warp_pkg.sv
// Shared types for the per-warp instruction buffer and its scoreboard.
// The register-ID width here is also used by the scoreboard.
package ibuffer_per_warp_pkg;

    localparam int REG_ID_W = 5;

    typedef struct packed {
        logic [REG_ID_W-1:0] src1;
        logic [REG_ID_W-1:0] src2;
        logic [REG_ID_W-1:0] dst;
        logic                src1_valid;
        logic                src2_valid;
        logic                dst_valid;
    } dec_fields_t;

    localparam int DEC_FIELDS_W = $bits(dec_fields_t);

    // Flag bits are meaningless for an empty head, so the scoreboard sees them cleared.
    function automatic dec_fields_t mask_valids(dec_fields_t f, logic head_valid);
        dec_fields_t m;
        m            = f;
        m.src1_valid = f.src1_valid & head_valid;
        m.src2_valid = f.src2_valid & head_valid;
        m.dst_valid  = f.dst_valid  & head_valid;
        return m;
    endfunction

endpackage

// File: rtl/ibuffer_per_warp_if.sv
// Decode / scoreboard / issue signal bundle around one warp's instruction buffer.
// The slave modport is the buffer; the master modport is its surrounding pipeline.
interface ibuffer_per_warp_if #(
    parameter int INSTR_W = 32
);
    import ibuffer_per_warp_pkg::*;

    logic                valid_ID_IB;
    logic [INSTR_W-1:0]  instr_ID_IB;
    logic [REG_ID_W-1:0] src1_ID_IB;
    logic [REG_ID_W-1:0] src2_ID_IB;
    logic [REG_ID_W-1:0] dst_ID_IB;
    logic                src1_valid_ID_IB;
    logic                src2_valid_ID_IB;
    logic                dst_valid_ID_IB;
    logic                full_IB_ID;
    logic                empty_IB;

    logic [REG_ID_W-1:0] src1_IB_Scb;
    logic [REG_ID_W-1:0] src2_IB_Scb;
    logic [REG_ID_W-1:0] dst_IB_Scb;
    logic                src1_valid_IB_Scb;
    logic                src2_valid_IB_Scb;
    logic                dst_valid_IB_Scb;
    logic                dependent_Scb_IB;
    logic                full_Scb_IB;

    logic                ready_IB_Issue;
    logic                issue_grant;
    logic [INSTR_W-1:0]  instr_IB_OC;
    logic                flush_IB;

    modport slave (
        input  valid_ID_IB, instr_ID_IB, src1_ID_IB, src2_ID_IB, dst_ID_IB,
        input  src1_valid_ID_IB, src2_valid_ID_IB, dst_valid_ID_IB,
        output full_IB_ID, empty_IB,
        output src1_IB_Scb, src2_IB_Scb, dst_IB_Scb,
        output src1_valid_IB_Scb, src2_valid_IB_Scb, dst_valid_IB_Scb,
        input  dependent_Scb_IB, full_Scb_IB,
        output ready_IB_Issue, instr_IB_OC,
        input  issue_grant, flush_IB
    );

    modport master (
        output valid_ID_IB, instr_ID_IB, src1_ID_IB, src2_ID_IB, dst_ID_IB,
        output src1_valid_ID_IB, src2_valid_ID_IB, dst_valid_ID_IB,
        input  full_IB_ID, empty_IB,
        input  src1_IB_Scb, src2_IB_Scb, dst_IB_Scb,
        input  src1_valid_IB_Scb, src2_valid_IB_Scb, dst_valid_IB_Scb,
        output dependent_Scb_IB, full_Scb_IB,
        input  ready_IB_Issue, instr_IB_OC,
        output issue_grant, flush_IB
    );

endinterface

// File: rtl/ibuf_fifo.sv
// Generic circular FIFO with occupancy count and synchronous flush.
// Read data is a combinational read of the head slot; there is no write-through.
module ibuf_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged before any same-cycle pop, so a pop never frees room for a push.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ibuffer_per_warp.sv
// Per-warp in-order instruction buffer feeding the scoreboard and issue stage.
// Head fields come straight from storage so the scoreboard hazard path has no loop through grant.
module ibuffer_per_warp
    import ibuffer_per_warp_pkg::*;
#(
    parameter int NUM_ENTRIES     = 2,
    parameter int LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES),
    parameter int INSTR_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ibuffer_per_warp_if.slave    bus
);

    localparam int ENTRY_W = INSTR_W + DEC_FIELDS_W;

    dec_fields_t        in_fields;
    dec_fields_t        head_fields;
    dec_fields_t        head_masked;
    logic [INSTR_W-1:0] head_instr;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               full;
    logic               empty;
    logic               ready;
    logic               pop;

    assign in_fields = '{src1:       bus.src1_ID_IB,
                         src2:       bus.src2_ID_IB,
                         dst:        bus.dst_ID_IB,
                         src1_valid: bus.src1_valid_ID_IB,
                         src2_valid: bus.src2_valid_ID_IB,
                         dst_valid:  bus.dst_valid_ID_IB};

    assign wr_entry = {bus.instr_ID_IB, in_fields};

    ibuf_fifo #(
        .DEPTH (NUM_ENTRIES),
        .WIDTH (ENTRY_W),
        .PTR_W (LOG_NUM_ENTRIES)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush_IB),
        .push    (bus.valid_ID_IB),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    assign {head_instr, head_fields} = rd_entry;
    assign head_masked = mask_valids(head_fields, !empty);

    // Flush blocks readiness so a grant in the flush cycle cannot pop a discarded entry.
    assign ready = !empty && !bus.dependent_Scb_IB && !bus.full_Scb_IB && !bus.flush_IB;
    assign pop   = bus.issue_grant && ready;

    assign bus.full_IB_ID        = full;
    assign bus.empty_IB          = empty;
    assign bus.ready_IB_Issue    = ready;
    assign bus.instr_IB_OC       = head_instr;
    assign bus.src1_IB_Scb       = head_fields.src1;
    assign bus.src2_IB_Scb       = head_fields.src2;
    assign bus.dst_IB_Scb        = head_fields.dst;
    assign bus.src1_valid_IB_Scb = head_masked.src1_valid;
    assign bus.src2_valid_IB_Scb = head_masked.src2_valid;
    assign bus.dst_valid_IB_Scb  = head_masked.dst_valid;

`ifdef IBUF_ASSERT_ON
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(bus.valid_ID_IB && full && !bus.flush_IB))
        else $error("push while instruction buffer full");

    a_no_grant_when_not_ready: assert property (@(posedge clk) disable iff (rst)
        !(bus.issue_grant && !ready))
        else $error("issue_grant while head not ready");
`endif

endmodule
